// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: access encodings, FSM states,
// and the lane extract/merge helpers also used by the core's load/store logic.
package dmem_pkg;

  // Store size encodings.
  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  // Load type encodings (funct3).
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWr,
    StResp,
    StErrResp
  } state_e;

  // Pull the addressed byte/half out of a word and extend it per the load type.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  load);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (load)
      LB:      res = {{24{b[7]}}, b};
      LH:      res = {{16{h[15]}}, h};
      LBU:     res = {24'h0, b};
      LHU:     res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Overlay store data onto an existing word; untouched lanes keep the old bytes.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  store);
    logic [31:0] res;
    res = word;
    case (store)
      SB: begin
        case (lane)
          2'd0:    res[7:0]   = wdata[7:0];
          2'd1:    res[15:8]  = wdata[7:0];
          2'd2:    res[23:16] = wdata[7:0];
          default: res[31:24] = wdata[7:0];
        endcase
      end
      SH: begin
        if (lane[1]) res[31:16] = wdata[15:0];
        else         res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with synchronous read. The read register only updates on
// a read strobe, so its value holds for as long as the responder needs it.
module dmem_ram #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned AW          = 6
) (
  input  logic          clk,
  input  logic          re,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write port and registered read port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side responder for core loads/stores: one request at a time, word RAM,
// read-modify-write for sub-word stores, extended load data, error reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned AW          = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_store,
  input  logic [2:0]  req_load,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  state_e        state_q;
  logic          we_q;
  logic [AW+1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [1:0]    store_q;
  logic [2:0]    load_q;
  logic          resp_valid_q;
  logic          resp_err_q;

  logic          is_half;
  logic          is_word;
  logic          bad_enc;
  logic          misaligned;
  logic          out_of_range;
  logic          illegal;

  logic          ram_re;
  logic          ram_we;
  logic [31:0]   ram_rdata;
  logic [31:0]   ram_wdata;

  // Classify the incoming request by access size and encoding legality.
  always_comb begin
    is_half = 1'b0;
    is_word = 1'b0;
    bad_enc = 1'b0;
    if (req_we) begin
      is_half = (req_store == SH);
      is_word = (req_store == SW);
      bad_enc = (req_store == 2'b11);
    end else begin
      is_half = (req_load == LH) || (req_load == LHU);
      is_word = (req_load == LW);
      bad_enc = !((req_load == LB) || (req_load == LH) || (req_load == LW) ||
                  (req_load == LBU) || (req_load == LHU));
    end
  end

  assign out_of_range = |req_addr[31:AW+2];
  assign misaligned   = (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
  assign illegal      = out_of_range | misaligned | bad_enc;

  // Control FSM: latches the request on accept and sequences RD/WR/response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      store_q      <= SW;
      load_q       <= LW;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr[AW+1:0];
            wdata_q <= req_wdata;
            store_q <= req_store;
            load_q  <= req_load;
            if (illegal) begin
              state_q      <= StErrResp;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (req_we && (req_store == SW)) begin
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd: begin
          if (we_q) begin
            state_q <= StWr;
          end else begin
            state_q      <= StResp;
            resp_valid_q <= 1'b1;
          end
        end
        StWr: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
        end
        StResp, StErrResp: begin
          if (resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A reset landing on the WR edge must not commit the write.
  assign ram_re    = (state_q == StRd);
  assign ram_we    = (state_q == StWr) && !reset;
  assign ram_wdata = lane_merge(ram_rdata, wdata_q, addr_q[1:0], store_q);

  dmem_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_ram (
    .clk  (clk),
    .re   (ram_re),
    .we   (ram_we),
    .addr (addr_q[AW+1:2]),
    .wdata(ram_wdata),
    .rdata(ram_rdata)
  );

  // RAM read register holds through RESP, so the extracted data stays stable.
  assign req_ready  = (state_q == StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = (state_q == StResp && !we_q) ?
                      lane_extract(ram_rdata, addr_q[1:0], load_q) : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of single transactions plus
// hand-written backpressure and reset-during-write sequences.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_store;
  logic [2:0]  req_load;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(
    .DEPTH_WORDS(64),
    .AW         (6)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_store (req_store),
    .req_load  (req_load),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  store;
    logic [2:0]  load;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [1:0] store, input logic [2:0] load,
                     input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.store = store;
    v.load = load; v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_lat = exp_lat;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts negedges after the accept edge until resp_valid, then handshakes.
  task automatic wait_resp(input string name, output logic [31:0] rdata, output logic err,
                           output int lat);
    lat = 0;
    rdata = '0;
    err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no resp_valid expected resp_valid within 20 cycles", name);
      lat = 99;
    end else begin
      rdata = resp_rdata;
      err = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic [31:0] rdata;
    logic        err;
    int          lat;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_store = v.store;
    req_load  = v.load;
    @(posedge clk);
    // Scramble inputs after accept; the DUT must use the latched copy.
    #1;
    req_valid = 1'b0;
    req_we    = ~v.we;
    req_addr  = v.addr ^ 32'h3;
    req_wdata = ~v.wdata;
    req_store = ~v.store;
    req_load  = ~v.load;
    wait_resp(v.name, rdata, err, lat);
    check({v.name, " rdata"}, rdata, v.exp_rdata);
    check({v.name, " err"}, {31'h0, err}, {31'h0, v.exp_err});
    check({v.name, " latency"}, lat, v.exp_lat);
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_store = 2'b10; req_load = 3'b010; resp_ready = 1'b0;

    add("sw 0x10",      1'b1, 32'h10,  32'hDEADBEEF, 2'b10, 3'b010, 32'h0,        1'b0, 2);
    add("lw 0x10 a",    1'b0, 32'h10,  32'h0,        2'b10, 3'b010, 32'hDEADBEEF, 1'b0, 2);
    add("sb 0x11",      1'b1, 32'h11,  32'hAAAAAA55, 2'b00, 3'b010, 32'h0,        1'b0, 3);
    add("lw 0x10 b",    1'b0, 32'h10,  32'h0,        2'b10, 3'b010, 32'hDEAD55EF, 1'b0, 2);
    add("lb 0x13",      1'b0, 32'h13,  32'h0,        2'b10, 3'b000, 32'hFFFFFFDE, 1'b0, 2);
    add("lbu 0x13",     1'b0, 32'h13,  32'h0,        2'b10, 3'b100, 32'h000000DE, 1'b0, 2);
    add("lh 0x12",      1'b0, 32'h12,  32'h0,        2'b10, 3'b001, 32'hFFFFDEAD, 1'b0, 2);
    add("lhu 0x10",     1'b0, 32'h10,  32'h0,        2'b10, 3'b101, 32'h000055EF, 1'b0, 2);
    add("lh 0x11 err",  1'b0, 32'h11,  32'h0,        2'b10, 3'b001, 32'h0,        1'b1, 1);
    add("sw 0x12 err",  1'b1, 32'h12,  32'h12345678, 2'b10, 3'b010, 32'h0,        1'b1, 1);
    add("lw oor err",   1'b0, 32'h100, 32'h0,        2'b10, 3'b010, 32'h0,        1'b1, 1);
    add("st 11 err",    1'b1, 32'h10,  32'h0,        2'b11, 3'b010, 32'h0,        1'b1, 1);
    add("ld 011 err",   1'b0, 32'h10,  32'h0,        2'b10, 3'b011, 32'h0,        1'b1, 1);
    add("lw hi err",    1'b0, 32'h80000010, 32'h0,   2'b10, 3'b010, 32'h0,        1'b1, 1);
    add("lhu 0x13 err", 1'b0, 32'h13,  32'h0,        2'b10, 3'b101, 32'h0,        1'b1, 1);
    add("lw 0x10 c",    1'b0, 32'h10,  32'h0,        2'b10, 3'b010, 32'hDEAD55EF, 1'b0, 2);
    add("sw 0x14",      1'b1, 32'h14,  32'h11223344, 2'b10, 3'b010, 32'h0,        1'b0, 2);
    add("sh 0x16",      1'b1, 32'h16,  32'hFFFF8765, 2'b01, 3'b010, 32'h0,        1'b0, 3);
    add("lw 0x14",      1'b0, 32'h14,  32'h0,        2'b10, 3'b010, 32'h87653344, 1'b0, 2);
    add("lh 0x16",      1'b0, 32'h16,  32'h0,        2'b10, 3'b001, 32'hFFFF8765, 1'b0, 2);
    add("lhu 0x14",     1'b0, 32'h14,  32'h0,        2'b10, 3'b101, 32'h00003344, 1'b0, 2);
    add("sb 0x14",      1'b1, 32'h14,  32'h00000080, 2'b00, 3'b010, 32'h0,        1'b0, 3);
    add("lb 0x14",      1'b0, 32'h14,  32'h0,        2'b10, 3'b000, 32'hFFFFFF80, 1'b0, 2);
    add("lbu 0x17",     1'b0, 32'h17,  32'h0,        2'b10, 3'b100, 32'h00000087, 1'b0, 2);
    add("lb 0x15",      1'b0, 32'h15,  32'h0,        2'b10, 3'b000, 32'h00000033, 1'b0, 2);
    add("sw 0xFC",      1'b1, 32'hFC,  32'h0BADF00D, 2'b10, 3'b010, 32'h0,        1'b0, 2);
    add("lw 0xFC",      1'b0, 32'hFC,  32'h0,        2'b10, 3'b010, 32'h0BADF00D, 1'b0, 2);
    add("sw 0x18",      1'b1, 32'h18,  32'hCAFEF00D, 2'b10, 3'b010, 32'h0,        1'b0, 2);
    add("sw 0x20 zero", 1'b1, 32'h20,  32'h00000000, 2'b10, 3'b010, 32'h0,        1'b0, 2);

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {31'h0, req_ready}, 32'h1);
    check("reset resp_valid", {31'h0, resp_valid}, 32'h0);
    check("reset resp_rdata", resp_rdata, 32'h0);
    check("reset resp_err", {31'h0, resp_err}, 32'h0);
    reset = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: lw 0x18 held for 5 cycles with a second request waiting.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h18; req_load = 3'b010; req_store = 2'b10;
    @(posedge clk);
    #1 req_addr = 32'h10;
    @(negedge clk);
    check("bp RD req_ready", {31'h0, req_ready}, 32'h0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("bp resp_valid", {31'h0, resp_valid}, 32'h1);
      check("bp resp_rdata", resp_rdata, 32'hCAFEF00D);
      check("bp req_ready", {31'h0, req_ready}, 32'h0);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    check("bp after hs resp_valid", {31'h0, resp_valid}, 32'h0);
    check("bp after hs req_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    wait_resp("bp held lw", rdata, err, lat);
    check("bp held lw rdata", rdata, 32'hDEAD55EF);
    check("bp held lw latency", lat, 2);

    // Reset during the WR cycle of sh 0x20 must drop the write and the response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h00001234;
    req_store = 2'b01;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("wr reset req_ready", {31'h0, req_ready}, 32'h1);
    check("wr reset resp_valid", {31'h0, resp_valid}, 32'h0);
    check("wr reset resp_rdata", resp_rdata, 32'h0);
    check("wr reset resp_err", {31'h0, resp_err}, 32'h0);
    begin
      vec_t v;
      v.name = "lw 0x20 after reset"; v.we = 1'b0; v.addr = 32'h20; v.wdata = '0;
      v.store = 2'b10; v.load = 3'b010; v.exp_rdata = 32'h0; v.exp_err = 1'b0; v.exp_lat = 2;
      run_vec(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the load/store control interface the core's decoder drives (MemWrite, Store size, Load size/sign).
- Accepts one request at a time over a valid/ready handshake and owns a word-wide synchronous RAM.
- Performs word, halfword and byte accesses. Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Reports misaligned and out-of-range accesses as errors. Sits between the core datapath and data storage in the multi-cycle-memory variant of the CPU.

Parameters:
DEPTH_WORDS, 64, number of 32-bit words in the RAM (power of 2).
AW, 6, word-index width; equals log2(DEPTH_WORDS).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept; high only in IDLE.
req_we  in  1  1 = store (MemWrite), 0 = load.
req_addr  in  32  byte address.
req_wdata  in  32  store data; the low byte/half is used for sub-word stores.
req_store  in  2  store size: 00 sb, 01 sh, 10 sw; 11 is illegal.
req_load  in  3  load type (funct3): 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others illegal.
resp_valid  out  1  response present.
resp_ready  in  1  core accepts response.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned, out-of-range or illegal-encoding request.

Behaviour:
- Interface decided: one clock; reset is synchronous and active-high, ports clk and reset.
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, state=IDLE. RAM contents are not cleared.
- Reset has priority in every state. Reset during WR commits no write. Reset during RESP drops the response.
- A request is accepted when req_valid & req_ready at edge T0. addr, we, wdata, store and load are latched at T0; later input changes are ignored.
- States:
  - IDLE -> ERR_RESP when the request is illegal.
  - IDLE -> RD for a load or an sb/sh store.
  - IDLE -> WR for sw.
  - RD -> RESP for a load.
  - RD -> WR for a sub-word store.
  - WR -> RESP.
  - RESP/ERR_RESP -> IDLE when resp_ready is high.
- Illegal request means any of:
  - word index (addr[31:2]) >= DEPTH_WORDS;
  - addr[0]=1 for a half access;
  - addr[1:0]!=00 for a word access;
  - an illegal store or load encoding.
- Illegal requests make no RAM access. resp_err=1 with rdata=0; resp_valid rises the cycle after accept.
- RD: issues the synchronous RAM read of word addr[AW+1:2]; data is registered at the end of RD.
- Load extraction:
  - byte lane = addr[1:0]; half lane = addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word.
- WR merge:
  - sb replaces byte lane addr[1:0] with wdata[7:0].
  - sh replaces half lane addr[1] with wdata[15:0].
  - sw writes wdata whole. Other bytes are preserved from the RD data.
- Latency, counted as resp_valid high N cycles after the accept edge:
  - load: 2;
  - sw: 2;
  - sb/sh: 3;
  - error: 1.
- Stores are committed in the WR cycle, before resp_valid.
- resp_valid, resp_rdata and resp_err hold stable until resp_ready is sampled high. They deassert the cycle after that handshake.
- req_ready is low from accept until return to IDLE, so there is no back-to-back overlap. Peak throughput is one request per latency+1 cycles with resp_ready tied high.
- A request presented while busy is not accepted and the requester must hold it. A same-cycle response handshake and a new request are not accepted together; the request is taken the next cycle in IDLE.

Decomposition:
- Shared package dmem_pkg:
  - store codes SB/SH/SW;
  - load codes LB/LH/LW/LBU/LHU;
  - the state enum;
  - a lane-extract function and a lane-merge function, reused by the core's own load/store extend logic.
- One sub-module, dmem_ram: DEPTH_WORDS x 32 single-port RAM with synchronous read, write enable and no byte enables. The responder instantiates it and owns the FSM and merge logic.

Test Plan:
- sw addr 0x10 data 0xDEADBEEF, then lw 0x10 -> store resp at T+2, err=0; load resp at T+2, rdata=0xDEADBEEF.
- After that word, sb addr 0x11 data 0x55, then lw 0x10 -> sb resp at T+3; word reads 0xDEAD55EF.
- From word 0xDEAD55EF: lb 0x13 -> 0xFFFFFFDE; lbu 0x13 -> 0x000000DE; lh 0x12 -> 0xFFFFDEAD; lhu 0x10 -> 0x000055EF.
- lh at 0x11, sw at 0x12, lw at 4*DEPTH_WORDS, req_store=11 -> each gives resp_err=1, rdata=0, latency 1. A following lw shows memory unchanged.
- Hold resp_ready=0 for 5 cycles after an lw -> resp_valid/rdata stay stable and req_ready stays 0; a request held valid meanwhile is accepted only after the response handshake.
- Assert reset during the WR cycle of sh 0x20 data 0x1234 over 0x0 -> all outputs at reset values the next cycle; a later lw 0x20 returns 0x00000000.
